// File: rtl/unflatten_stream_pkg.sv
// Shared NN layer package: stream state type, default layer sizes,
// and the index-width helper used by the flattener and layer blocks.
package unflatten_stream_pkg;

   localparam int DEF_BITS = 18;
   localparam int DEF_SIZE = 784;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Index width for a vector of 'size' elements, never below 1 bit.
   function automatic int idx_w(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/unflatten_stream.sv
// Unflattener: captures a packed vector on load, then streams its
// elements out one per valid/ready handshake, element 0 first.
//   clk, rst_n      : clock, async active-low reset
//   load, flat_in   : capture strobe and packed input vector
//   busy            : elements remain to be emitted
//   out_data/index  : current element and its position
//   out_valid/ready : output handshake, out_last marks SIZE-1
//   done            : one-cycle pulse after the final handshake
module unflatten_stream
   import unflatten_stream_pkg::*;
#(
   parameter int BITS  = DEF_BITS,
   parameter int SIZE  = DEF_SIZE,
   parameter int IDX_W = idx_w(SIZE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [BITS*SIZE-1:0]   flat_in,
   output logic                   busy,
   output logic signed [BITS-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDX_W-1:0]       out_index,
   output logic                   out_last,
   output logic                   done
);

   localparam int W = BITS * SIZE;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

   state_t           state;
   state_t           state_nx;
   logic [W-1:0]     shadow;
   logic [IDX_W-1:0] cnt;
   logic             hs;
   logic             at_last;
   logic             take;

   assign hs      = out_valid & out_ready;
   assign at_last = (cnt == LAST_IDX);
   assign take    = (state == IDLE) & load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (load) state_nx = STREAM;
         end
         STREAM: begin
            if (hs && at_last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == STREAM);
      busy      = (state == STREAM);
      out_last  = (state == STREAM) & at_last;
      out_index = cnt;
      out_data  = shadow[BITS-1:0];
   end

   // Every handshake shifts the shadow, so after the final element
   // the register is already zero-filled while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         cnt    <= '0;
         done   <= 1'b0;
      end else begin
         done <= hs & at_last;
         if (take) begin
            shadow <= flat_in;
            cnt    <= '0;
         end else if (hs) begin
            shadow <= shadow >> BITS;
            cnt    <= at_last ? '0 : cnt + IDX_W'(1);
         end
      end
   end

endmodule

// File: doc/unflatten_stream.md
Name: unflatten_stream

Overview:
- Inverse of the layer-output flattener. Accepts one packed vector of SIZE signed BITS-wide elements on a load strobe.
- Streams the elements back out one per handshake, element 0 first, over a valid/ready interface.
- Sits between a flattened-activation producer and the next NN layer's serial MAC input. Signals completion with a one-cycle done pulse.

Parameters:
- BITS, 18, width of one signed element.
- SIZE, 784, number of elements in the packed vector (must be ≥1).
- IDX_W, $clog2(SIZE) (minimum 1), width of out_index.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  strobe; captures flat_in when idle
- flat_in  input  BITS*SIZE  packed vector; element i = flat_in[i*BITS +: BITS], bit j of element i at position i*BITS+j
- busy  output  1  high while elements remain to be emitted
- out_data  output signed  BITS  current element
- out_valid  output  1  out_data/out_index/out_last valid
- out_ready  input  1  consumer accepts when high together with out_valid
- out_index  output  IDX_W  index of current element
- out_last  output  1  high with element SIZE-1
- done  output  1  one-cycle pulse after final element accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset asserted at any time, including mid-stream, immediately clears:
  - state to IDLE
  - busy, out_valid, out_last, done to 0
  - out_index to 0 and out_data to 0
  - the held shadow vector to 0
- States: IDLE and STREAM. The encoding is a 1-bit enum.
- IDLE:
  - load=1 at a rising edge copies flat_in into the shadow register, sets cnt=0, and moves to STREAM.
  - From the next cycle: out_valid=1, busy=1, out_data=element 0, out_index=0.
  - Load-to-first-valid latency is 1 cycle.
- STREAM:
  - out_data is always shadow[BITS-1:0].
  - Handshake = out_valid & out_ready. On a handshake that is not the last element:
    - shadow shifts right by BITS, with zero fill;
    - cnt increments;
    - the next element is presented in the following cycle with no bubble, so throughput is 1 element/cycle.
  - With out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable and the shadow does not shift.
  - out_last = (cnt == SIZE-1) while out_valid.
  - On the handshake with out_last=1:
    - next state is IDLE;
    - out_valid, busy and out_last drop next cycle;
    - done=1 for exactly that one cycle;
    - out_index returns to 0.
- load while busy: ignored. The shadow is not disturbed and no error is flagged.
- load during the done cycle: accepted, because the state is already IDLE. The next stream's element 0 is valid the following cycle.
- flat_in: sampled only on an accepted load. Changes at other times have no effect.
- out_data in IDLE: holds the zero-filled shadow value, but is don't-care for consumers.
- Arithmetic: no sign extension or arithmetic on data; bits pass through unchanged. cnt has IDX_W bits and never wraps, because it stops at SIZE-1.
- SIZE=1: element 0 carries out_last=1. Done follows its handshake.

Decomposition:
- Shared NN package holds:
  - the state typedef (IDLE, STREAM);
  - a function idx_w(size) returning max(1,$clog2(size)), reused by the flattener and other layer blocks;
  - default BITS=18 and SIZE=784 constants.
- No sub-module. The single module uses a shift-register shadow plus counter, roughly 120–160 lines of RTL.

Test Plan:
- Basic stream: BITS=4, SIZE=3, flat_in=12'hA53, load 1 cycle, out_ready held 1.
  - Required: out_data 3,5,-6 (4'hA) on consecutive cycles starting 1 cycle after load.
  - out_index 0,1,2; out_last only on index 2; done pulse one cycle after third handshake.
- Backpressure: same stimulus, out_ready low for 3 cycles on index 1.
  - Required: out_data=5 and out_index=1 held stable throughout; no element skipped or duplicated; total stream length 3.
- Load while busy: mid-stream, pulse load with flat_in=12'hFFF.
  - Required: remaining elements still come from 12'hA53; busy stays high until the end.
- Back-to-back: assert load in the done cycle with flat_in=12'h123.
  - Required: element 3 valid the next cycle; second stream 3,2,1 with correct index and last.
- Async reset mid-stream: drop rst_n between clock edges during index 1.
  - Required: out_valid, busy, done and out_last go 0 immediately without waiting for an edge.
  - After release, the block stays idle with no output until a new load.
- Default params: BITS=18, SIZE=784, flat_in element i = i-392.
  - Required: 784 handshakes in exact order; out_index reaches 783 with out_last; exactly one done pulse.
